// File: rtl/biriscv_csr_counters_if.sv
// CSR access bus between the biRISC-V CSR unit (master) and the counter bank (slave).
// Strobe semantics: there is no valid/ready pair. csr_ren_i qualifies csr_raddr_i
// in the same cycle, and rdata/hit/fault answer combinationally. csr_we_i
// qualifies csr_waddr_i/csr_wdata_i, and the write lands at the next clock edge.
// The slave never stalls, so neither strobe needs to be held.
interface biriscv_csr_counters_if;
  logic        csr_ren_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic        csr_fault_o;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;

  modport master (
    output csr_ren_i, csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
    input  csr_rdata_o, csr_hit_o, csr_fault_o
  );

  modport slave (
    input  csr_ren_i, csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
    output csr_rdata_o, csr_hit_o, csr_fault_o
  );
endinterface

// File: rtl/biriscv_csr_counters.sv
// Performance-counter / timer CSR bank for the biRISC-V CSR unit.
// Holds mcycle, minstret, NUM_COUNTERS mhpmcounters with event selectors,
// mcountinhibit and mcounteren. Reads are combinational at issue and
// return pre-write state. Writes land at the next edge and beat increments.
// Optional feature macro: BIRISCV_CSR_MTIMECMP_EN adds mtimecmp (7C0/7C1)
// and a registered machine timer interrupt. Without it, timer_intr_o is 0.
// This block has no FSM; all state is counters and configuration registers.
module biriscv_csr_counters #(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 64,
  parameter int NUM_EVENTS   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 priv_i,
  biriscv_csr_counters_if.slave      csr,
  input  logic [1:0]                 instret_i,
  input  logic [NUM_EVENTS-1:0]      event_i,
  output logic                       timer_intr_o
);

  localparam int NC = (NUM_COUNTERS > 0) ? NUM_COUNTERS : 1;
  localparam int EW = $clog2(NUM_EVENTS + 1);

  // Implemented bits of mcountinhibit/mcounteren: CY (0), IR (2), HPM3.. (3+).
  localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_COUNTERS) - 64'd1) << 3;
  localparam logic [31:0] CNT_MASK = 32'h0000_0005 | HPM_BITS[31:0];

  logic [COUNTER_W-1:0] mcycle_q;
  logic [COUNTER_W-1:0] minstret_q;
  logic [COUNTER_W-1:0] hpm_q     [NC];
  logic [EW-1:0]        hpm_evt_q [NC];
  logic [31:0]          inhibit_q;
  logic [31:0]          counteren_q;

  // Partial-write helpers: lo keeps the high part, hi keeps bits [31:0].
  function automatic logic [COUNTER_W-1:0] put_lo(input logic [COUNTER_W-1:0] old,
                                                  input logic [31:0] d);
    return {old[COUNTER_W-1:32], d};
  endfunction

  function automatic logic [COUNTER_W-1:0] put_hi(input logic [COUNTER_W-1:0] old,
                                                  input logic [31:0] d);
    return {d[COUNTER_W-33:0], old[31:0]};
  endfunction

  // ---------------------------------------------------------------- read side
  logic [4:0]           rd_n;
  logic                 rd_hit;
  logic                 rd_shadow;
  logic [31:0]          rd_data;
  logic [COUNTER_W-1:0] rd_cnt;
  logic [63:0]          rd_cnt64;
  logic [EW-1:0]        rd_evt;
  logic                 rd_cnt_space;

`ifdef BIRISCV_CSR_MTIMECMP_EN
  logic [63:0] mtimecmp_q;
`endif

  // Decode the read address and select the pre-write register value.
  always_comb begin
    rd_n         = csr.csr_raddr_i[4:0];
    rd_hit       = 1'b0;
    rd_shadow    = 1'b0;
    rd_data      = 32'h0;
    rd_cnt       = '0;
    rd_evt       = '0;
    // Counter space: x00..x1F / x80..x9F, excluding N=1 (time is not here).
    rd_cnt_space = (csr.csr_raddr_i[6:5] == 2'b00) && (rd_n != 5'd1);

    if (rd_n == 5'd0) begin
      rd_cnt = mcycle_q;
    end else if (rd_n == 5'd2) begin
      rd_cnt = minstret_q;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rd_n == 5'(i + 3)) begin
        rd_cnt = hpm_q[i];
        rd_evt = hpm_evt_q[i];
      end
    end
    rd_cnt64 = 64'(rd_cnt);

    if ((csr.csr_raddr_i[11:8] == 4'hB || csr.csr_raddr_i[11:8] == 4'hC) && rd_cnt_space) begin
      rd_hit    = 1'b1;
      rd_shadow = (csr.csr_raddr_i[11:8] == 4'hC);
      rd_data   = csr.csr_raddr_i[7] ? rd_cnt64[63:32] : rd_cnt64[31:0];
    end else if (csr.csr_raddr_i == 12'h320) begin
      rd_hit  = 1'b1;
      rd_data = inhibit_q;
    end else if (csr.csr_raddr_i[11:5] == 7'h19 && rd_n >= 5'd3) begin
      rd_hit  = 1'b1;
      rd_data = 32'(rd_evt);
    end else if (csr.csr_raddr_i == 12'h306) begin
      rd_hit  = 1'b1;
      rd_data = counteren_q;
    end
`ifdef BIRISCV_CSR_MTIMECMP_EN
    else if (csr.csr_raddr_i == 12'h7C0) begin
      rd_hit  = 1'b1;
      rd_data = mtimecmp_q[31:0];
    end else if (csr.csr_raddr_i == 12'h7C1) begin
      rd_hit  = 1'b1;
      rd_data = mtimecmp_q[63:32];
    end
`endif
  end

  // Drive the read responses, all gated by the read strobe.
  always_comb begin
    csr.csr_hit_o   = csr.csr_ren_i && rd_hit;
    csr.csr_rdata_o = (csr.csr_ren_i && rd_hit) ? rd_data : 32'h0;
    csr.csr_fault_o = csr.csr_ren_i && rd_hit && rd_shadow &&
                      (priv_i != 2'd3) && !counteren_q[rd_n];
  end

  // --------------------------------------------------------------- write side
  logic       wr_cnt;
  logic       wr_hi;
  logic [4:0] wr_n;
  logic       wr_inh;
  logic       wr_en;
  logic       wr_evt;
  logic [EW-1:0] wr_evt_val;

  // Classify the write address. Shadow (Cxx) writes match nothing.
  always_comb begin
    wr_n       = csr.csr_waddr_i[4:0];
    wr_hi      = csr.csr_waddr_i[7];
    wr_cnt     = csr.csr_we_i && (csr.csr_waddr_i[11:8] == 4'hB) &&
                 (csr.csr_waddr_i[6:5] == 2'b00);
    wr_inh     = csr.csr_we_i && (csr.csr_waddr_i == 12'h320);
    wr_en      = csr.csr_we_i && (csr.csr_waddr_i == 12'h306);
    wr_evt     = csr.csr_we_i && (csr.csr_waddr_i[11:5] == 7'h19) && (wr_n >= 5'd3);
    // mhpmevent is WARL: out-of-range selectors collapse to "count nothing".
    wr_evt_val = (csr.csr_wdata_i > 32'(NUM_EVENTS)) ? '0 : csr.csr_wdata_i[EW-1:0];
  end

  // Selected event per counter; index 0 of the extended vector is constant 0.
  logic [NUM_EVENTS:0] event_ext;
  logic [NC-1:0]       hpm_inc;

  // Look up each counter's selected event pulse.
  always_comb begin
    event_ext = {event_i, 1'b0};
    hpm_inc   = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      hpm_inc[i] = event_ext[hpm_evt_q[i]];
    end
  end

  // mcycle: write wins over increment; inhibit bit 0 freezes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q <= '0;
    end else if (wr_cnt && wr_n == 5'd0) begin
      mcycle_q <= wr_hi ? put_hi(mcycle_q, csr.csr_wdata_i) : put_lo(mcycle_q, csr.csr_wdata_i);
    end else if (!inhibit_q[0]) begin
      mcycle_q <= mcycle_q + COUNTER_W'(1);
    end
  end

  // minstret: adds retired instructions (dual issue) unless inhibit bit 2 set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      minstret_q <= '0;
    end else if (wr_cnt && wr_n == 5'd2) begin
      minstret_q <= wr_hi ? put_hi(minstret_q, csr.csr_wdata_i) : put_lo(minstret_q, csr.csr_wdata_i);
    end else if (!inhibit_q[2]) begin
      minstret_q <= minstret_q + COUNTER_W'(instret_i);
    end
  end

  // mhpmcounters and their event selectors.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NC; i++) begin
      if (rst_i) begin
        hpm_q[i]     <= '0;
        hpm_evt_q[i] <= '0;
      end else begin
        if (wr_cnt && wr_n == 5'(i + 3)) begin
          hpm_q[i] <= wr_hi ? put_hi(hpm_q[i], csr.csr_wdata_i) : put_lo(hpm_q[i], csr.csr_wdata_i);
        end else if (!inhibit_q[i + 3] && hpm_inc[i]) begin
          hpm_q[i] <= hpm_q[i] + COUNTER_W'(1);
        end
        if (wr_evt && wr_n == 5'(i + 3)) begin
          hpm_evt_q[i] <= wr_evt_val;
        end
      end
    end
  end

  // mcountinhibit / mcounteren keep only implemented bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_q   <= 32'h0;
      counteren_q <= 32'h0;
    end else begin
      if (wr_inh) inhibit_q   <= csr.csr_wdata_i & CNT_MASK;
      if (wr_en)  counteren_q <= csr.csr_wdata_i & CNT_MASK;
    end
  end

`ifdef BIRISCV_CSR_MTIMECMP_EN
  logic timer_q;

  // mtimecmp storage and the registered mcycle >= mtimecmp comparison.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtimecmp_q <= '1;
      timer_q    <= 1'b0;
    end else begin
      if (csr.csr_we_i && csr.csr_waddr_i == 12'h7C0) mtimecmp_q[31:0]  <= csr.csr_wdata_i;
      if (csr.csr_we_i && csr.csr_waddr_i == 12'h7C1) mtimecmp_q[63:32] <= csr.csr_wdata_i;
      timer_q <= (64'(mcycle_q) >= mtimecmp_q);
    end
  end

  assign timer_intr_o = timer_q;
`else
  assign timer_intr_o = 1'b0;
`endif

endmodule

// File: tb/tb_biriscv_csr_counters.sv
// Directed bench for biriscv_csr_counters with default parameters
// (4 hpm counters, 64-bit, 8 events). Inputs change 1 ns after the rising
// edge, and outputs are sampled a further 1 ns later.
module tb_biriscv_csr_counters;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] priv_i = 2'd3;
  logic [1:0] instret_i = 2'd0;
  logic [7:0] event_i = 8'h0;
  logic       timer_intr_o;

  biriscv_csr_counters_if csr_bus ();

  biriscv_csr_counters #(
    .NUM_COUNTERS(4),
    .COUNTER_W   (64),
    .NUM_EVENTS  (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .priv_i      (priv_i),
    .csr         (csr_bus.slave),
    .instret_i   (instret_i),
    .event_i     (event_i),
    .timer_intr_o(timer_intr_o)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd_data;
  logic        rd_hit;
  logic        rd_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_bus.csr_ren_i   = 1'b1;
    csr_bus.csr_raddr_i = a;
    #1;
    rd_data  = csr_bus.csr_rdata_o;
    rd_hit   = csr_bus.csr_hit_o;
    rd_fault = csr_bus.csr_fault_o;
    csr_bus.csr_ren_i   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd(a);
    chk(tag, rd_data, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_bus.csr_we_i    = 1'b1;
    csr_bus.csr_waddr_i = a;
    csr_bus.csr_wdata_i = d;
    step();
    csr_bus.csr_we_i    = 1'b0;
  endtask

  // Safety net: the sequence below is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    csr_bus.csr_ren_i   = 1'b0;
    csr_bus.csr_raddr_i = 12'h0;
    csr_bus.csr_we_i    = 1'b0;
    csr_bus.csr_waddr_i = 12'h0;
    csr_bus.csr_wdata_i = 32'h0;

    // Reset, then 10 idle cycles.
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (10) step();
    chk_rd("mcycle_after_10", 12'hB00, 32'd10);
    chk_rd("mcycleh_reset", 12'hB80, 32'd0);
    chk_rd("minstret_reset", 12'hB02, 32'd0);
    chk_rd("hpm3_reset", 12'hB03, 32'd0);
    chk("timer_reset", 32'(timer_intr_o), 32'd0);

    // Lo write near wrap: written value held one cycle, then carry into hi.
    wr(12'hB00, 32'hFFFF_FFFF);
    chk_rd("mcycle_write_held", 12'hB00, 32'hFFFF_FFFF);
    chk_rd("mcycleh_before_carry", 12'hB80, 32'd0);
    step();
    step();
    chk_rd("mcycle_after_carry", 12'hB00, 32'd1);
    chk_rd("mcycleh_after_carry", 12'hB80, 32'd1);

    // Event counting on mhpmcounter3 with selector 2 (event_i[1]).
    wr(12'h323, 32'd2);
    chk_rd("mhpmevent3_rb", 12'h323, 32'd2);
    for (int i = 0; i < 5; i++) begin
      event_i = 8'h02;
      step();
      event_i = 8'h00;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      event_i = 8'h01;
      step();
      event_i = 8'h00;
    end
    chk_rd("hpm3_events", 12'hB03, 32'd5);
    chk_rd("hpm3h_events", 12'hB83, 32'd0);
    wr(12'h323, 32'd9);
    chk_rd("mhpmevent3_warl", 12'h323, 32'd0);
    wr(12'h324, 32'd8);
    chk_rd("mhpmevent4_max", 12'h324, 32'd8);
    rd(12'hB07);
    chk("hpm7_unimpl_hit", 32'(rd_hit), 32'd1);
    chk("hpm7_unimpl_data", rd_data, 32'd0);
    rd(12'hB01);
    chk("b01_not_hit", 32'(rd_hit), 32'd0);

    // Inhibit masking and frozen mcycle.
    wr(12'h320, 32'hFFFF_FFFF);
    chk_rd("mcountinhibit_mask", 12'h320, 32'h0000_007D);
    wr(12'hB00, 32'h0000_0100);
    step();
    chk_rd("mcycle_inhibited", 12'hB00, 32'h0000_0100);

    // minstret inhibited, then counting 2 per cycle.
    wr(12'h320, 32'h4);
    instret_i = 2'd2;
    repeat (4) step();
    instret_i = 2'd0;
    chk_rd("minstret_inhibited", 12'hB02, 32'd0);
    wr(12'h320, 32'h0);
    instret_i = 2'd2;
    repeat (4) step();
    instret_i = 2'd0;
    chk_rd("minstret_plus8", 12'hB02, 32'd8);

    // Shadow access control with mcycle frozen at a known value.
    wr(12'h320, 32'h1);
    wr(12'hB00, 32'h1234_5678);
    wr(12'hB80, 32'h0000_0005);
    priv_i = 2'd0;
    rd(12'hC00);
    chk("c00_fault_no_en", 32'(rd_fault), 32'd1);
    chk("c00_data_on_fault", rd_data, 32'h1234_5678);
    wr(12'h306, 32'h1);
    rd(12'hC00);
    chk("c00_fault_en", 32'(rd_fault), 32'd0);
    chk("c00_data_en", rd_data, 32'h1234_5678);
    chk_rd("c80_data_en", 12'hC80, 32'h0000_0005);
    rd(12'hC02);
    chk("c02_fault_user", 32'(rd_fault), 32'd1);
    chk("c02_data", rd_data, 32'd8);
    priv_i = 2'd3;
    rd(12'hC02);
    chk("c02_fault_machine", 32'(rd_fault), 32'd0);
    priv_i = 2'd0;
    csr_bus.csr_raddr_i = 12'hC02;
    #1;
    chk("no_ren_hit", 32'(csr_bus.csr_hit_o), 32'd0);
    chk("no_ren_fault", 32'(csr_bus.csr_fault_o), 32'd0);
    chk("no_ren_data", csr_bus.csr_rdata_o, 32'd0);
    priv_i = 2'd3;
    wr(12'hC00, 32'h0);
    chk_rd("shadow_write_ignored", 12'hB00, 32'h1234_5678);

    // Same-cycle read and write: read sees the old value.
    csr_bus.csr_we_i    = 1'b1;
    csr_bus.csr_waddr_i = 12'hB00;
    csr_bus.csr_wdata_i = 32'h0000_AAAA;
    chk_rd("rw_same_cycle_old", 12'hB00, 32'h1234_5678);
    step();
    csr_bus.csr_we_i = 1'b0;
    chk_rd("rw_same_cycle_new", 12'hB00, 32'h0000_AAAA);
    wr(12'h306, 32'hFFFF_FFFF);
    chk_rd("mcounteren_mask", 12'h306, 32'h0000_007D);

    // Reset mid-operation with a coincident write.
    csr_bus.csr_we_i    = 1'b1;
    csr_bus.csr_waddr_i = 12'hB00;
    csr_bus.csr_wdata_i = 32'h0000_0007;
    rst_i = 1'b1;
    step();
    csr_bus.csr_we_i = 1'b0;
    rst_i = 1'b0;
    chk_rd("rst_mcycle", 12'hB00, 32'd0);
    chk_rd("rst_minstret", 12'hB02, 32'd0);
    chk_rd("rst_mcounteren", 12'h306, 32'd0);
    chk_rd("rst_mhpmevent4", 12'h324, 32'd0);
    chk_rd("rst_mcountinhibit", 12'h320, 32'd0);

`ifdef BIRISCV_CSR_MTIMECMP_EN
    // mcycle is 0 here and increments every edge from now on.
    rd(12'h7C0);
    chk("mtimecmp_lo_reset", rd_data, 32'hFFFF_FFFF);
    wr(12'h7C1, 32'h0);
    wr(12'h7C0, 32'd20);
    chk("timer_low_early", 32'(timer_intr_o), 32'd0);
    repeat (18) step();
    chk_rd("mcycle_at_20", 12'hB00, 32'd20);
    chk("timer_low_at_20", 32'(timer_intr_o), 32'd0);
    step();
    chk("timer_high_after_20", 32'(timer_intr_o), 32'd1);
    wr(12'h7C0, 32'hFFFF_FFFF);
    chk("timer_still_high", 32'(timer_intr_o), 32'd1);
    step();
    chk("timer_dropped", 32'(timer_intr_o), 32'd0);
`else
    rd(12'h7C0);
    chk("mtimecmp_lo_not_hit", 32'(rd_hit), 32'd0);
    rd(12'h7C1);
    chk("mtimecmp_hi_not_hit", 32'(rd_hit), 32'd0);
    repeat (25) step();
    chk("timer_tied_low", 32'(timer_intr_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
